// File: rtl/sha256_msg_loader.sv
// Message loader for the SHA-256 hasher: packs a big-endian byte stream into
// 32-bit words, writes them to the shared message memory, then runs the
// hasher start/done handshake and pulses complete when the hash is finished.
module sha256_msg_loader #(
    parameter int unsigned NUM_OF_WORDS = 40
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        go,
    input  logic [15:0] load_base,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_owner,
    output logic        sha_start,
    input  logic        sha_done,
    output logic        busy,
    output logic        complete
);

    localparam logic [15:0] LastWord = 16'(NUM_OF_WORDS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StFlush,
        StWaitLow,
        StWaitHigh
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] base_q, base_d;
    logic [15:0] word_idx_q, word_idx_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    // Only the first three bytes of a word need storing; the fourth comes
    // straight from s_data when the word is written.
    logic [23:0] pack_q, pack_d;
    logic        mem_we_q, mem_we_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        mem_owner_q, mem_owner_d;
    logic        sha_start_q, sha_start_d;
    logic        complete_q, complete_d;
    logic        accept;

    // s_ready is a pure state decode, independent of s_valid.
    assign s_ready   = (state_q == StFill);
    assign busy      = (state_q != StIdle);
    assign accept    = s_ready & s_valid;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_owner = mem_owner_q;
    assign sha_start = sha_start_q;
    assign complete  = complete_q;

    // Next-state and registered-output logic for the load/handshake FSM.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        word_idx_d  = word_idx_q;
        byte_idx_d  = byte_idx_q;
        pack_d      = pack_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_owner_d = mem_owner_q;
        sha_start_d = sha_start_q;
        complete_d  = 1'b0;

        case (state_q)
            StIdle: begin
                if (go) begin
                    base_d      = load_base;
                    word_idx_d  = 16'd0;
                    byte_idx_d  = 2'd0;
                    mem_owner_d = 1'b1;
                    state_d     = StFill;
                end
            end
            StFill: begin
                if (accept) begin
                    pack_d     = {pack_q[15:0], s_data};
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = base_q + word_idx_q;  // wraps mod 2^16
                        mem_wdata_d = {pack_q, s_data};
                        word_idx_d  = word_idx_q + 16'd1;
                        if (word_idx_q == LastWord) begin
                            state_d = StFlush;
                        end
                    end
                end
            end
            StFlush: begin
                // Hand memory back before raising start so they never overlap.
                mem_owner_d = 1'b0;
                sha_start_d = 1'b1;
                state_d     = StWaitLow;
            end
            StWaitLow: begin
                if (!sha_done) begin
                    sha_start_d = 1'b0;
                    state_d     = StWaitHigh;
                end
            end
            StWaitHigh: begin
                if (sha_done) begin
                    complete_d = 1'b1;
                    state_d    = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers; reset discards any partial word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            base_q      <= 16'd0;
            word_idx_q  <= 16'd0;
            byte_idx_q  <= 2'd0;
            pack_q      <= 24'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 16'd0;
            mem_wdata_q <= 32'd0;
            mem_owner_q <= 1'b0;
            sha_start_q <= 1'b0;
            complete_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            word_idx_q  <= word_idx_d;
            byte_idx_q  <= byte_idx_d;
            pack_q      <= pack_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_owner_q <= mem_owner_d;
            sha_start_q <= sha_start_d;
            complete_q  <= complete_d;
        end
    end

endmodule

// File: tb/tb_sha256_msg_loader.sv
// Testbench for sha256_msg_loader: byte-stream driver with a reference packer
// feeding an expected-write queue, a write monitor, and a simple hasher model.
module tb_sha256_msg_loader;

    localparam int unsigned N = 40;
    localparam int HASH_DELAY = 300;

    logic        clk;
    logic        rst_n;
    logic        go;
    logic [15:0] load_base;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_owner;
    logic        sha_start;
    logic        sha_done;
    logic        busy;
    logic        complete;

    sha256_msg_loader #(.NUM_OF_WORDS(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .go        (go),
        .load_base (load_base),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_owner (mem_owner),
        .sha_start (sha_start),
        .sha_done  (sha_done),
        .busy      (busy),
        .complete  (complete)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Expected writes {addr, data}, pushed when the 4th byte of a word is driven.
    logic [47:0] exp_q[$];
    logic [15:0] m_base;
    int          m_widx;
    int          m_bidx;
    logic [31:0] m_pack;

    int wr_count = 0;
    int neg_cnt = 0;
    int last_wr = 0;
    int overlap_err = 0;
    bit check_spacing = 0;

    // Hasher model: drops done one cycle after start, raises it HASH_DELAY later.
    logic hbusy;
    int   hcnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sha_done <= 1'b1;
            hbusy    <= 1'b0;
            hcnt     <= 0;
        end else if (!hbusy && sha_start && sha_done) begin
            sha_done <= 1'b0;
            hbusy    <= 1'b1;
            hcnt     <= HASH_DELAY - 1;
        end else if (hbusy) begin
            if (hcnt == 0) begin
                sha_done <= 1'b1;
                hbusy    <= 1'b0;
            end else begin
                hcnt <= hcnt - 1;
            end
        end
    end

    // Write monitor: pops the scoreboard on every memory write.
    always @(negedge clk) begin
        logic [47:0] e;
        if (mem_we) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr=%h data=%h, none expected",
                         mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== e) begin
                    n_fail++;
                    $display("FAIL write_data: got addr=%h data=%h, expected addr=%h data=%h",
                             mem_addr, mem_wdata, e[47:32], e[31:0]);
                end
            end
            wr_count++;
            if (check_spacing && wr_count > 1) begin
                n_cmp++;
                if (neg_cnt - last_wr != 4) begin
                    n_fail++;
                    $display("FAIL write_spacing: got %0d cycles, expected 4",
                             neg_cnt - last_wr);
                end
            end
            last_wr = neg_cnt;
        end
        if (sha_start && mem_owner) overlap_err++;
        neg_cnt++;
    end

    task automatic model_init(input logic [15:0] base);
        m_base = base;
        m_widx = 0;
        m_bidx = 0;
        m_pack = 32'd0;
    endtask

    // Enter and leave at a negedge. The session is in FILL on return.
    task automatic start_session(input logic [15:0] base);
        go        = 1'b1;
        load_base = base;
        model_init(base);
        @(negedge clk);
        go = 1'b0;
    endtask

    // Drive bytes first, first+1, ... with gap_pct% idle cycles. Returns at the
    // negedge right after the last byte is accepted.
    task automatic feed(input int nbytes, input int gap_pct, input logic [7:0] first);
        int sent = 0;
        int guard = 0;
        logic rdy;
        logic [7:0] b;
        while (sent < nbytes && guard < 20000) begin
            rdy     = s_ready;
            b       = first + 8'(sent);
            s_data  = b;
            s_valid = ($urandom_range(99, 0) >= gap_pct);
            @(posedge clk);
            if (s_valid && rdy) begin
                m_pack = {m_pack[23:0], b};
                m_bidx++;
                if (m_bidx == 4) begin
                    exp_q.push_back({m_base + 16'(m_widx), m_pack});
                    m_widx++;
                    m_bidx = 0;
                end
                sent++;
            end
            @(negedge clk);
            guard++;
        end
        s_valid = 1'b0;
        if (sent != nbytes) begin
            n_cmp++;
            n_fail++;
            $display("FAIL feed_timeout: got %0d bytes accepted, expected %0d", sent, nbytes);
        end
    endtask

    // Bounded wait, at negedges, for the complete pulse.
    task automatic wait_complete(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (complete) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        go        = 1'b0;
        load_base = 16'd0;
        s_data    = 8'd0;
        s_valid   = 1'b0;
        #3;
        n_cmp++;
        if ({s_ready, mem_we, mem_addr, mem_wdata, mem_owner, sha_start, busy, complete} !== '0)
        begin
            n_fail++;
            $display("FAIL reset_in_reset: got outputs=%h, expected 0",
                     {s_ready, mem_we, mem_addr, mem_wdata, mem_owner, sha_start, busy, complete});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (s_ready !== 1'b0)    begin n_fail++; $display("FAIL reset_s_ready: got %b, expected 0", s_ready); end
        n_cmp++; if (mem_we !== 1'b0)     begin n_fail++; $display("FAIL reset_mem_we: got %b, expected 0", mem_we); end
        n_cmp++; if (mem_addr !== 16'd0)  begin n_fail++; $display("FAIL reset_mem_addr: got %h, expected 0", mem_addr); end
        n_cmp++; if (mem_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_mem_wdata: got %h, expected 0", mem_wdata); end
        n_cmp++; if (mem_owner !== 1'b0)  begin n_fail++; $display("FAIL reset_mem_owner: got %b, expected 0", mem_owner); end
        n_cmp++; if (sha_start !== 1'b0)  begin n_fail++; $display("FAIL reset_sha_start: got %b, expected 0", sha_start); end
        n_cmp++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        n_cmp++; if (complete !== 1'b0)   begin n_fail++; $display("FAIL reset_complete: got %b, expected 0", complete); end
    endtask

    // Continuous stream plus detailed flush / handshake / complete timing.
    task automatic test_stream;
        bit seen;
        wr_count      = 0;
        check_spacing = 1;
        start_session(16'h0010);
        n_cmp++;
        if (s_ready !== 1'b1 || mem_owner !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_entry: got s_ready=%b mem_owner=%b, expected 1/1", s_ready, mem_owner);
        end
        feed(N * 4, 0, 8'h00);
        // Cycle n+1: FLUSH with the final write on the bus.
        n_cmp++;
        if (mem_we !== 1'b1 || mem_owner !== 1'b1 || sha_start !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_cycle: got we=%b owner=%b start=%b, expected 1/1/0",
                     mem_we, mem_owner, sha_start);
        end
        @(negedge clk);
        // Cycle n+2: memory released, start raised.
        n_cmp++;
        if (mem_we !== 1'b0 || mem_owner !== 1'b0 || sha_start !== 1'b1) begin
            n_fail++;
            $display("FAIL start_cycle: got we=%b owner=%b start=%b, expected 0/0/1",
                     mem_we, mem_owner, sha_start);
        end
        check_spacing = 0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!sha_start) begin
                seen = 1;
                break;
            end
        end
        n_cmp++;
        if (!seen || sha_done !== 1'b0) begin
            n_fail++;
            $display("FAIL start_fall: got fell=%b done=%b, expected 1/0", seen, sha_done);
        end
        seen = 0;
        for (int i = 0; i < 1000; i++) begin
            if (sha_done) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (!seen || complete !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL done_rise: got seen=%b complete=%b busy=%b, expected 1/0/1",
                     seen, complete, busy);
        end
        @(negedge clk);
        n_cmp++;
        if (complete !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL complete_pulse: got complete=%b busy=%b, expected 1/0", complete, busy);
        end
        // go in the complete cycle is accepted; the next test continues this session.
        go        = 1'b1;
        load_base = 16'h0010;
        model_init(16'h0010);
        @(negedge clk);
        go = 1'b0;
        n_cmp++;
        if (complete !== 1'b0 || busy !== 1'b1 || s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL go_in_complete: got complete=%b busy=%b s_ready=%b, expected 0/1/1",
                     complete, busy, s_ready);
        end
        n_cmp++;
        if (wr_count !== N || exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL stream_count: got %0d writes, %0d pending, expected %0d/0",
                     wr_count, exp_q.size(), N);
        end
    endtask

    task automatic test_gaps;
        bit ok;
        wr_count = 0;
        feed(N * 4, 30, 8'h00);
        wait_complete(ok);
        n_cmp++;
        if (!ok || wr_count !== N || exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL gaps_session: got complete=%b writes=%0d pending=%0d, expected 1/%0d/0",
                     ok, wr_count, exp_q.size(), N);
        end
        @(negedge clk);
    endtask

    task automatic test_wrap;
        bit ok;
        wr_count = 0;
        start_session(16'hFFF0);
        feed(N * 4, 10, 8'h30);
        wait_complete(ok);
        n_cmp++;
        if (!ok || wr_count !== N || exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL wrap_session: got complete=%b writes=%0d pending=%0d, expected 1/%0d/0",
                     ok, wr_count, exp_q.size(), N);
        end
        @(negedge clk);
    endtask

    task automatic test_ignored;
        bit ok;
        bit found;
        wr_count = 0;
        // Bytes offered in IDLE must not be taken.
        s_valid = 1'b1;
        s_data  = 8'hEE;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (s_ready !== 1'b0 || busy !== 1'b0 || mem_we !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_bytes: got s_ready=%b busy=%b we=%b, expected 0/0/0",
                         s_ready, busy, mem_we);
            end
        end
        s_valid = 1'b0;
        start_session(16'h0200);
        feed(10, 0, 8'h40);
        // go during FILL with a different base must be ignored.
        go        = 1'b1;
        load_base = 16'h7777;
        @(negedge clk);
        go = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || s_ready !== 1'b1 || mem_owner !== 1'b1) begin
            n_fail++;
            $display("FAIL go_in_fill: got busy=%b s_ready=%b owner=%b, expected 1/1/1",
                     busy, s_ready, mem_owner);
        end
        feed(N * 4 - 10, 0, 8'h4A);
        found = 0;
        for (int i = 0; i < 50; i++) begin
            if (busy && !mem_owner && !sha_start && !sha_done) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (!found) begin
            n_fail++;
            $display("FAIL reach_wait_high: got not reached, expected reached");
        end
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || complete !== 1'b0 || s_ready !== 1'b0 || sha_start !== 1'b0) begin
            n_fail++;
            $display("FAIL go_in_wait_high: got busy=%b complete=%b s_ready=%b start=%b, expected 1/0/0/0",
                     busy, complete, s_ready, sha_start);
        end
        wait_complete(ok);
        n_cmp++;
        if (!ok || wr_count !== N || exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL ignored_session: got complete=%b writes=%0d pending=%0d, expected 1/%0d/0",
                     ok, wr_count, exp_q.size(), N);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        bit ok;
        wr_count = 0;
        start_session(16'h0040);
        feed(17, 0, 8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({s_ready, mem_we, mem_addr, mem_wdata, mem_owner, sha_start, busy, complete} !== '0)
        begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got outputs=%h, expected 0",
                     {s_ready, mem_we, mem_addr, mem_wdata, mem_owner, sha_start, busy, complete});
        end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        wr_count = 0;
        start_session(16'h0100);
        feed(N * 4, 0, 8'hA0);
        wait_complete(ok);
        n_cmp++;
        if (!ok || wr_count !== N || exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_session: got complete=%b writes=%0d pending=%0d, expected 1/%0d/0",
                     ok, wr_count, exp_q.size(), N);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_gaps();
        test_wrap();
        test_ignored();
        test_reset_mid();
        n_cmp++;
        if (overlap_err != 0) begin
            n_fail++;
            $display("FAIL start_owner_overlap: got %0d cycles, expected 0", overlap_err);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sha256_msg_loader.md
# sha256_msg_loader

Upstream feeder for the SHA-256 hasher. It accepts the message as a big-endian byte stream, packs the bytes into 32-bit words and writes them into the shared message memory. When the whole message is written it launches the hasher through its `start`/`done` pair and signals completion. While loading it owns the memory port through an external mux; at all other times the hasher owns the port.

## Interface
- `NUM_OF_WORDS`, default 40: message length in 32-bit words. Equals the hasher's `NUM_OF_WORDS`. Legal range 1..65535.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `go`  in  1  request to begin a load session. Sampled only in IDLE.
- `load_base`  in  16  word address of message word 0. Sampled with `go`. Must equal the hasher's `input_addr`.
- `s_data`  in  8  message byte.
- `s_valid`  in  1  `s_data` valid.
- `s_ready`  out  1  loader accepts a byte this cycle.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  16  memory word address.
- `mem_wdata`  out  32  memory write data.
- `mem_owner`  out  1  1 = external mux routes the loader to memory; 0 = the hasher owns memory.
- `sha_start`  out  1  start request to the hasher.
- `sha_done`  in  1  hasher `done`. Level signal; high whenever the hasher is idle.
- `busy`  out  1  session in progress (state != IDLE).
- `complete`  out  1  one-cycle pulse when the hash is finished.

## Operation
- States: IDLE, FILL, FLUSH, WAIT_LOW, WAIT_HIGH.
- IDLE
  - `s_ready`=0.
  - `go`=1: latch `load_base`, clear `word_idx` (16 b) and `byte_idx` (2 b), set `mem_owner`=1, go to FILL.
- FILL
  - `s_ready`=1. This is a decode of the state register; it has no combinational path from `s_valid`.
  - Each handshake (`s_valid`&`s_ready`) shifts the byte into the pack register. The first byte of a word lands in bits [31:24], so word = {b0,b1,b2,b3}.
  - On the 4th byte of a word, the following are registered: `mem_we`=1, `mem_addr`=base+`word_idx` (mod 2^16), `mem_wdata`=packed word. Then `word_idx`++.
  - Otherwise `mem_we`=0.
  - When the 4th byte of word `NUM_OF_WORDS`-1 is accepted, go to FLUSH.
- FLUSH (one cycle)
  - The final write is on the bus.
  - Next edge: `mem_we`=0, `mem_owner`=0, `sha_start`=1, go to WAIT_LOW.
- WAIT_LOW
  - Hold `sha_start`=1 until `sha_done`=0 is sampled.
  - Then `sha_start`=0 and go to WAIT_HIGH.
- WAIT_HIGH
  - On `sha_done`=1: `complete`=1 for one cycle, go to IDLE.
- `go` while `busy` is ignored. A byte offered outside FILL is not accepted.
- `mem_addr` and `mem_wdata` hold their last value when `mem_we`=0.
- Reset (any state, including mid-FILL) returns to IDLE and discards the partial word. All outputs return to their reset values asynchronously.

## Timing
- Reset values: `s_ready`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_owner`, `sha_start`, `busy` and `complete` are all 0.
- All outputs are registered or are decodes of registers.
- Write latency: the 4th byte is accepted in cycle n; `mem_we` is high in cycle n+1, for exactly one cycle.
- Back-to-back bytes sustain 1 byte/cycle, which gives a write every 4th cycle.
- Last byte accepted in cycle n:
  - cycle n+1: FLUSH, final write, `mem_owner`=1.
  - cycle n+2: `mem_owner`=0, `sha_start`=1.
- `sha_start` is never high while `mem_owner`=1.
- `complete` is high the cycle after `sha_done` is sampled high in WAIT_HIGH. `busy` is 0 in that same cycle.
- `go` in the `complete` cycle is accepted; FILL starts the following cycle.
- Minimum session length: 4·`NUM_OF_WORDS`+2 cycles plus hasher time.

## Test plan
- **Continuous stream.** N=40, `load_base`=0x0010, bytes 0x00..0x9F with `s_valid` held high. Expect exactly 40 writes, one every 4 cycles. First write: addr 0x0010, data 0x00010203. Last write: addr 0x0037, data 0x9C9D9E9F. `sha_start` rises 2 cycles after the last byte.
- **Random `s_valid` gaps.** Same data as above with 30% gaps. Expect an identical write sequence, with no byte lost or duplicated.
- **Hasher handshake.** Hasher model drops `sha_done` 1 cycle after `sha_start` and raises it 300 cycles later. Expect `sha_start` to fall after `sha_done`=0 is sampled, and `complete` to pulse exactly once, 1 cycle after `sha_done` rises.
- **Address wrap.** `load_base`=0xFFF0. Expect write addresses 0xFFF0..0xFFFF, then 0x0000..0x0017.
- **Ignored inputs.** Pulse `go` during FILL and WAIT_HIGH; offer bytes in IDLE. Expect no state change and `s_ready`=0 in IDLE.
- **Reset mid-FILL.** Assert reset after 17 bytes. Expect all outputs 0 immediately. After release, `go` with `load_base`=0x0100 makes the first write to 0x0100 using only new bytes.
